adc_row_buffer: RTL and testbench

//   Downstream of the camera exposure/readout controller. Captures ADC conversion results while the

---
 rtl/camera_pkg.sv | 27 ++
 rtl/adc_row_buffer_sync_fifo.sv | 56 +++++
 rtl/adc_row_buffer.sv | 196 +++++++++++++++++++
 tb/tb_adc_row_buffer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
`default_nettype none
// ============================================================================
// Package : camera_pkg
// Brief   : Shared state encodings, error bit indices and defaults for the
//           ADC row buffer.
// Rev     : 1.0 - initial release
// ============================================================================
package camera_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int ERR_W          = 4;

    typedef enum logic [2:0] {
        WAIT_R1 = 3'd0,
        ROW1    = 3'd1,
        WAIT_R2 = 3'd2,
        ROW2    = 3'd3,
        FLUSH   = 3'd4
    } state_t;

    localparam int ERR_OVERFLOW    = 0;
    localparam int ERR_ILLEGAL_SEL = 1;
    localparam int ERR_SHORT_ROW   = 2;
    localparam int ERR_ABORT       = 3;

endpackage
`default_nettype wire

// File: rtl/adc_row_buffer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock first-word fall-through FIFO with synchronous flush.
// Rev    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int          c_aw      = $clog2(DEPTH);
    localparam logic [c_aw:0] c_ptr_one = (c_aw + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra MSB on each pointer separates the full and empty cases.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

    assign w_do_pop  = pop & ~empty & ~flush;
    assign w_do_push = push & ~flush & (~full | w_do_pop);

    assign dout = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/adc_row_buffer.sv
`default_nettype none
// ============================================================================
// Module : adc_row_buffer
// Brief  : Captures two-row ADC bursts, tags and buffers each sample, streams
//          them on a valid/ready port and tracks sticky protocol errors.
// Rev    : 1.0 - initial release
// ============================================================================
module adc_row_buffer
    import camera_pkg::*;
#(
    parameter int DATA_W          = DEFAULT_DATA_W,
    parameter int SAMPLES_PER_ROW = 5,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adc,
    input  logic              nre1,
    input  logic              nre2,
    input  logic              erase,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_row,
    output logic              out_last,
    output logic              frame_done,
    output logic [ERR_W-1:0]  err_flags,
    input  logic              clear_err
);

    localparam int                 c_cnt_w   = $clog2(SAMPLES_PER_ROW + 1);
    localparam logic [c_cnt_w-1:0] c_spr     = c_cnt_w'(SAMPLES_PER_ROW);
    localparam logic [c_cnt_w-1:0] c_spr_m1  = c_cnt_w'(SAMPLES_PER_ROW - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam int                 c_ent_w   = DATA_W + 2;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [ERR_W-1:0]   r_err;
    logic [ERR_W-1:0]   w_err_set;

    logic w_cap1;
    logic w_cap2;
    logic w_both_low;
    logic w_abort;
    logic w_push_req;
    logic w_tag_row;
    logic w_tag_last;
    logic w_flush;
    logic w_err_sel;
    logic w_err_short;
    logic w_pop;
    logic w_fifo_full;
    logic w_fifo_empty;

    logic [c_ent_w-1:0] w_din;
    logic [c_ent_w-1:0] w_dout;

    assign w_cap1     = adc & ~nre1 &  nre2;
    assign w_cap2     = adc &  nre1 & ~nre2;
    assign w_both_low = adc & ~nre1 & ~nre2;
    assign w_abort    = erase & ((r_state == ROW1) || (r_state == WAIT_R2) ||
                                 (r_state == ROW2));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_push_req  = 1'b0;
        w_tag_row   = 1'b0;
        w_tag_last  = 1'b0;
        w_flush     = 1'b0;
        w_err_sel   = w_both_low;
        w_err_short = 1'b0;
        frame_done  = 1'b0;

        if (w_abort) begin
            // Abort discards the whole partial frame, including any capture now.
            w_flush     = 1'b1;
            w_state_nxt = WAIT_R1;
        end else begin
            case (r_state)
                WAIT_R1: begin
                    if (w_cap1) begin
                        w_state_nxt = ROW1;
                        w_push_req  = 1'b1;
                        w_cnt_nxt   = c_cnt_one;
                    end else if (w_cap2) begin
                        w_err_sel = 1'b1;
                    end
                end
                ROW1: begin
                    if (!adc) begin
                        w_err_short = (r_cnt < c_spr);
                        w_state_nxt = WAIT_R2;
                    end else if (w_cap1) begin
                        if (r_cnt < c_spr) begin
                            w_push_req = 1'b1;
                            w_cnt_nxt  = r_cnt + c_cnt_one;
                        end else begin
                            w_err_sel = 1'b1;
                        end
                    end else if (w_cap2) begin
                        w_err_sel = 1'b1;
                    end
                end
                WAIT_R2: begin
                    if (w_cap2) begin
                        w_state_nxt = ROW2;
                        w_push_req  = 1'b1;
                        w_tag_row   = 1'b1;
                        w_tag_last  = (SAMPLES_PER_ROW == 1);
                        w_cnt_nxt   = c_cnt_one;
                    end else if (w_cap1) begin
                        w_err_sel = 1'b1;
                    end
                end
                ROW2: begin
                    if (!adc) begin
                        w_err_short = (r_cnt < c_spr);
                        w_state_nxt = FLUSH;
                    end else if (w_cap2) begin
                        if (r_cnt < c_spr) begin
                            w_push_req = 1'b1;
                            w_tag_row  = 1'b1;
                            w_tag_last = (r_cnt == c_spr_m1);
                            w_cnt_nxt  = r_cnt + c_cnt_one;
                        end else begin
                            w_err_sel = 1'b1;
                        end
                    end else if (w_cap1) begin
                        w_err_sel = 1'b1;
                    end
                end
                FLUSH: begin
                    if (w_cap1 || w_cap2) w_err_sel = 1'b1;
                    if (w_fifo_empty) begin
                        frame_done  = 1'b1;
                        w_state_nxt = WAIT_R1;
                    end
                end
                default: w_state_nxt = WAIT_R1;
            endcase
        end
    end

    assign w_pop = out_valid & out_ready;
    assign w_din = {w_tag_last, w_tag_row, adc_data};

    always_comb begin
        w_err_set                  = '0;
        w_err_set[ERR_OVERFLOW]    = w_push_req & w_fifo_full & ~w_pop;
        w_err_set[ERR_ILLEGAL_SEL] = w_err_sel;
        w_err_set[ERR_SHORT_ROW]   = w_err_short;
        w_err_set[ERR_ABORT]       = w_abort;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WAIT_R1;
            r_cnt   <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // A clear and a fresh error in the same cycle keep the fresh error.
            r_err   <= (clear_err ? '0 : r_err) | w_err_set;
        end
    end

    sync_fifo #(
        .WIDTH (c_ent_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (w_flush),
        .push  (w_push_req),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // Storage is not reset, so payload outputs are forced low while empty.
    assign out_valid = ~w_fifo_empty;
    assign out_data  = out_valid ? w_dout[DATA_W-1:0] : '0;
    assign out_row   = out_valid & w_dout[DATA_W];
    assign out_last  = out_valid & w_dout[DATA_W+1];
    assign err_flags = r_err;

endmodule
`default_nettype wire

// File: tb/tb_adc_row_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_adc_row_buffer
// Brief  : Self-checking bench for adc_row_buffer against a queue-based model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_adc_row_buffer;

    localparam int DW    = 8;
    localparam int SPR   = 5;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic          last;
        logic          row;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset, adc, nre1, nre2, erase, out_ready, clear_err;
    logic [DW-1:0] adc_data;
    logic          out_valid, out_row, out_last, frame_done;
    logic [DW-1:0] out_data;
    logic [3:0]    err_flags;

    int n_checks = 0;
    int n_errors = 0;
    int fd_seen  = 0;
    bit rand_ready = 0;
    bit rand_clr   = 0;
    logic [DW+1:0] log_q[$];

    // Behavioural model: which row is expected, whether a burst is running,
    // whether the frame is waiting to drain, and a queue standing in for the FIFO.
    ent_t       mq[$];
    int         m_row      = 1;
    bit         m_active   = 0;
    bit         m_draining = 0;
    int         m_cnt      = 0;
    logic [3:0] m_err      = '0;

    adc_row_buffer #(.DATA_W(DW), .SAMPLES_PER_ROW(SPR), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .adc(adc), .nre1(nre1), .nre2(nre2), .erase(erase),
        .adc_data(adc_data), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_row(out_row), .out_last(out_last),
        .frame_done(frame_done), .err_flags(err_flags), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit c1, c2, own, oth, pop, push;
        logic [3:0] ne;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_row = 1; m_active = 0; m_draining = 0; m_cnt = 0; m_err = '0;
        end else begin
            c1  = adc && !nre1 && nre2;
            c2  = adc && nre1 && !nre2;
            own = (m_row == 1) ? c1 : c2;
            oth = (m_row == 1) ? c2 : c1;
            pop = (mq.size() != 0) && out_ready;
            push = 0;
            e = '0;
            ne = '0;
            ne[1] = adc && !nre1 && !nre2;
            if (m_draining) begin
                if (c1 || c2) ne[1] = 1'b1;
                if (mq.size() == 0) begin
                    m_draining = 0;
                    m_row = 1;
                end
            end else if (erase && (m_active || m_row == 2)) begin
                mq.delete();
                pop = 0;
                ne[3] = 1'b1;
                m_active = 0;
                m_row = 1;
            end else if (!m_active) begin
                if (own) begin
                    m_active = 1;
                    m_cnt = 1;
                    push = 1;
                    e = {(m_row == 2) && (SPR == 1), m_row == 2, adc_data};
                end else if (oth) begin
                    ne[1] = 1'b1;
                end
            end else if (!adc) begin
                if (m_cnt < SPR) ne[2] = 1'b1;
                m_active = 0;
                if (m_row == 1) m_row = 2;
                else m_draining = 1;
            end else if (own) begin
                if (m_cnt < SPR) begin
                    push = 1;
                    e = {(m_row == 2) && (m_cnt == SPR - 1), m_row == 2, adc_data};
                    m_cnt++;
                end else begin
                    ne[1] = 1'b1;
                end
            end else if (oth) begin
                ne[1] = 1'b1;
            end
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(e);
                else ne[0] = 1'b1;
            end
            m_err = (clear_err ? 4'b0 : m_err) | ne;
        end
    end

    always @(negedge clk) begin : compare
        ent_t h;
        h = '0;
        if (mq.size() != 0) h = mq[0];
        chk("out_valid",  {31'b0, out_valid},  {31'b0, mq.size() != 0});
        chk("out_data",   {24'b0, out_data},   {24'b0, h.data});
        chk("out_row",    {31'b0, out_row},    {31'b0, h.row});
        chk("out_last",   {31'b0, out_last},   {31'b0, h.last});
        chk("frame_done", {31'b0, frame_done}, {31'b0, m_draining && mq.size() == 0});
        chk("err_flags",  {28'b0, err_flags},  {28'b0, m_err});
        if (!reset && out_valid && out_ready) log_q.push_back({out_last, out_row, out_data});
        if (!reset && frame_done) fd_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        if (rand_clr)   clear_err = ($urandom_range(0, 15) == 0);
    endtask

    task automatic drive(input bit a, input bit n1, input bit n2, input bit er, input logic [DW-1:0] d);
        adc = a; nre1 = n1; nre2 = n2; erase = er; adc_data = d;
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 1, 1, 0, '0);
    endtask

    task automatic row(input int r, input int n, input logic [DW-1:0] base, input bit bad);
        for (int i = 0; i < n; i++) begin
            if (bad && $urandom_range(0, 11) == 0) drive(1, 0, 0, 0, 8'hEE);
            drive(1, r != 1, r != 2, 0, base + DW'(i));
        end
    endtask

    task automatic do_reset();
        reset = 1;
        idle(2);
        reset = 0;
        log_q.delete();
    endtask

    task automatic wait_done(input int budget);
        int start = fd_seen;
        int k = 0;
        while (fd_seen == start && k < budget) begin
            idle(1);
            k++;
        end
        chk("frame_done_seen", fd_seen - start, 1);
    endtask

    logic [DW+1:0] exp1 [10] = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h014,
                                 10'h120, 10'h121, 10'h122, 10'h123, 10'h324};

    initial begin
        int fd0;
        reset = 1; adc = 0; nre1 = 1; nre2 = 1; erase = 0; adc_data = '0;
        out_ready = 0; clear_err = 0;
        idle(2);
        chk("reset_valid", {31'b0, out_valid}, 0);
        chk("reset_err",   {28'b0, err_flags}, 0);

        // Nominal frame
        do_reset();
        out_ready = 1;
        fd0 = fd_seen;
        row(1, 5, 8'h10, 0); idle(1); row(2, 5, 8'h20, 0);
        wait_done(20);
        idle(3);
        chk("t1_fd_count", fd_seen - fd0, 1);
        chk("t1_len", log_q.size(), 10);
        for (int i = 0; i < 10 && i < log_q.size(); i++) chk("t1_sample", {22'b0, log_q[i]}, {22'b0, exp1[i]});
        chk("t1_err", {28'b0, err_flags}, 0);

        // Backpressure overflow
        do_reset();
        out_ready = 0;
        row(1, 5, 8'h10, 0); idle(1); row(2, 5, 8'h20, 0); idle(3);
        chk("t2_err", {28'b0, err_flags}, 4'b0001);
        chk("t2_held_valid", {31'b0, out_valid}, 1);
        out_ready = 1;
        wait_done(30);
        chk("t2_len", log_q.size(), 8);
        if (log_q.size() == 8) chk("t2_tail", {22'b0, log_q[7]}, 10'h122);

        // Illegal select inside row 1
        do_reset();
        out_ready = 1;
        row(1, 2, 8'h10, 0); drive(1, 0, 0, 0, 8'hEE); row(1, 3, 8'h12, 0); idle(1);
        chk("t3_err", {28'b0, err_flags}, 4'b0010);
        row(2, 5, 8'h20, 0);
        wait_done(20);
        chk("t3_len", log_q.size(), 10);

        // Short row 1
        do_reset();
        out_ready = 1;
        row(1, 3, 8'h10, 0); idle(1);
        chk("t4_err", {28'b0, err_flags}, 4'b0100);
        row(2, 5, 8'h20, 0);
        wait_done(20);
        chk("t4_len", log_q.size(), 8);
        if (log_q.size() == 8) chk("t4_last", {22'b0, log_q[7]}, 10'h324);

        // Erase abort mid row 2, then clear
        do_reset();
        out_ready = 0;
        fd0 = fd_seen;
        row(1, 5, 8'h10, 0); idle(1); row(2, 2, 8'h20, 0);
        drive(0, 1, 1, 1, '0);
        chk("t5_valid", {31'b0, out_valid}, 0);
        chk("t5_err", {28'b0, err_flags}, 4'b1000);
        idle(5);
        chk("t5_no_fd", fd_seen - fd0, 0);
        clear_err = 1; idle(1); clear_err = 0;
        chk("t5_cleared", {28'b0, err_flags}, 0);

        // Reset mid row 1
        do_reset();
        out_ready = 0;
        row(1, 3, 8'h30, 0);
        reset = 1; drive(1, 0, 1, 0, 8'h33); reset = 0;
        chk("t6_valid", {31'b0, out_valid}, 0);
        chk("t6_err", {28'b0, err_flags}, 0);
        drive(1, 1, 0, 0, 8'h40);
        chk("t6_wait_r1", {28'b0, err_flags}, 4'b0010);
        drive(1, 0, 1, 0, 8'h41);
        chk("t6_capture", {31'b0, out_valid}, 1);
        idle(1);

        // Randomized frames
        do_reset();
        rand_ready = 1;
        rand_clr = 1;
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 19) == 0) begin
                reset = 1; idle(1); reset = 0;
            end
            row(1, $urandom_range(1, 7), DW'($urandom), 1);
            idle($urandom_range(1, 2));
            if ($urandom_range(0, 9) == 0) drive(0, 1, 1, 1, '0);
            row(2, $urandom_range(1, 7), DW'($urandom), 1);
            if ($urandom_range(0, 9) == 0) drive(0, 1, 1, 1, '0);
            idle($urandom_range(1, 12));
        end
        rand_ready = 0;
        rand_clr = 0;
        out_ready = 1;
        clear_err = 0;
        idle(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
